// File: rtl/pipeline_tracker.sv
// Instruction-tracking pipeline registers with stall, multi-stage flush and retire.
// Define PERF_COUNTERS_EN to build the saturating performance counters.
module pipeline_tracker #(
    parameter int XLEN        = 32,
    parameter int NSTAGES     = 5,
    parameter int STALL_STAGE = 1,
    parameter int FLUSH_STAGE = 2,
    parameter int CNT_W       = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [XLEN-1:0]             i_pc,
    input  logic [31:0]                 i_instr,
    input  logic                        i_stall,
    input  logic                        i_flush,
    output logic                        o_fetch_ack,
    output logic [NSTAGES-2:0]          o_valid,
    output logic [32*(NSTAGES-1)-1:0]   o_instr,
    output logic [XLEN*(NSTAGES-1)-1:0] o_pc,
    output logic                        o_retire,
    output logic [XLEN-1:0]             o_retire_pc,
    output logic [CNT_W-1:0]            o_cyc_cnt,
    output logic [CNT_W-1:0]            o_ret_cnt,
    output logic [CNT_W-1:0]            o_stall_cnt,
    output logic [CNT_W-1:0]            o_flush_cnt
);

    localparam int          NR  = NSTAGES - 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Stage k lives at slot k-1 of these packed vectors.
    logic [NR-1:0]      v_q,   v_d;
    logic [XLEN*NR-1:0] pc_q,  pc_d;
    logic [32*NR-1:0]   ins_q, ins_d;
    logic               stall_eff;

    assign stall_eff = i_stall & ~i_flush;

    always_comb begin
        v_d   = {v_q[NR-2:0], 1'b1};
        pc_d  = {pc_q[XLEN*(NR-1)-1:0], i_pc};
        ins_d = {ins_q[32*(NR-1)-1:0], i_instr};
        for (int k = 1; k <= NR; k++) begin
            if ((i_flush && k <= FLUSH_STAGE) ||
                (stall_eff && k == STALL_STAGE + 1)) begin
                v_d[k-1]              = 1'b0;
                pc_d[XLEN*k-1 -: XLEN] = '0;
                ins_d[32*k-1 -: 32]    = NOP;
            end else if (stall_eff && k <= STALL_STAGE) begin
                v_d[k-1]              = v_q[k-1];
                pc_d[XLEN*k-1 -: XLEN] = pc_q[XLEN*k-1 -: XLEN];
                ins_d[32*k-1 -: 32]    = ins_q[32*k-1 -: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q   <= '0;
            pc_q  <= '0;
            ins_q <= {NR{NOP}};
        end else begin
            v_q   <= v_d;
            pc_q  <= pc_d;
            ins_q <= ins_d;
        end
    end

    assign o_fetch_ack = ~i_stall & ~i_flush;
    assign o_valid     = v_q;
    assign o_pc        = pc_q;
    assign o_instr     = ins_q;
    assign o_retire    = v_q[NR-1];
    assign o_retire_pc = pc_q[XLEN*NR-1 -: XLEN];

`ifdef PERF_COUNTERS_EN
    logic [CNT_W-1:0] cyc_q, ret_q, stl_q, fls_q;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] c,
        input logic             en
    );
        return (en && c != '1) ? c + CNT_W'(1) : c;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
            ret_q <= '0;
            stl_q <= '0;
            fls_q <= '0;
        end else begin
            cyc_q <= sat_inc(cyc_q, 1'b1);
            ret_q <= sat_inc(ret_q, v_q[NR-1]);
            stl_q <= sat_inc(stl_q, stall_eff);
            fls_q <= sat_inc(fls_q, i_flush);
        end
    end

    assign o_cyc_cnt   = cyc_q;
    assign o_ret_cnt   = ret_q;
    assign o_stall_cnt = stl_q;
    assign o_flush_cnt = fls_q;
`else
    assign o_cyc_cnt   = '0;
    assign o_ret_cnt   = '0;
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_tracker.sv
// Randomised bench for pipeline_tracker against a stage-array reference model.
// A second instance with 4-bit counters exercises saturation.
module tb_pipeline_tracker;

    localparam int NS = 5;
    localparam int NR = NS - 1;
    localparam int SS = 1;
    localparam int FS = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [31:0] i_pc = '0;
    logic [31:0] i_instr = '0;
    logic i_stall = 1'b0;
    logic i_flush = 1'b0;

    logic            fetch_ack, retire, s_fetch_ack, s_retire;
    logic [NR-1:0]   valid, s_valid;
    logic [32*NR-1:0] instr, pc, s_instr, s_pc;
    logic [31:0]     retire_pc, s_retire_pc;
    logic [31:0]     cyc_cnt, ret_cnt, stall_cnt, flush_cnt;
    logic [3:0]      s_cyc, s_ret, s_stl, s_fls;

    pipeline_tracker #(.XLEN(32), .NSTAGES(NS), .STALL_STAGE(SS),
                       .FLUSH_STAGE(FS), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .i_pc(i_pc), .i_instr(i_instr),
        .i_stall(i_stall), .i_flush(i_flush), .o_fetch_ack(fetch_ack),
        .o_valid(valid), .o_instr(instr), .o_pc(pc), .o_retire(retire),
        .o_retire_pc(retire_pc), .o_cyc_cnt(cyc_cnt), .o_ret_cnt(ret_cnt),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    pipeline_tracker #(.XLEN(32), .NSTAGES(NS), .STALL_STAGE(SS),
                       .FLUSH_STAGE(FS), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .i_pc(i_pc), .i_instr(i_instr),
        .i_stall(i_stall), .i_flush(i_flush), .o_fetch_ack(s_fetch_ack),
        .o_valid(s_valid), .o_instr(s_instr), .o_pc(s_pc), .o_retire(s_retire),
        .o_retire_pc(s_retire_pc), .o_cyc_cnt(s_cyc), .o_ret_cnt(s_ret),
        .o_stall_cnt(s_stl), .o_flush_cnt(s_fls)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [31:0] pc;
        logic [31:0] ins;
    } st_t;

    st_t    m [1:NR];
    longint c32 [4];
    longint c4 [4];
    int     checks = 0;
    int     failures = 0;
    bit     run = 1'b0;

    function automatic st_t bub();
        st_t b;
        b.v = 1'b0;
        b.pc = '0;
        b.ins = 32'h13;
        return b;
    endfunction

    function automatic longint sat(longint v, int w);
        longint lim = (longint'(1) << w) - 1;
        return (v < lim) ? v + 1 : v;
    endfunction

    function automatic longint ec(longint v);
`ifdef PERF_COUNTERS_EN
        return v;
`else
        return (v < 0) ? v : 0;
`endif
    endfunction

    function automatic logic [31:0] mk_ins(logic [31:0] p);
        return {p[29:0], 2'b11} ^ 32'h5A00_0000;
    endfunction

    task automatic m_reset();
        for (int k = 1; k <= NR; k++) m[k] = bub();
        for (int i = 0; i < 4; i++) begin
            c32[i] = 0;
            c4[i] = 0;
        end
    endtask

    task automatic m_edge(bit st, bit fl, logic [31:0] p, logic [31:0] w);
        st_t n [1:NR];
        bit  inc [4];
        inc[0] = 1'b1;
        inc[1] = m[NR].v;
        inc[2] = st && !fl;
        inc[3] = fl;
        n[1].v = 1'b1;
        n[1].pc = p;
        n[1].ins = w;
        for (int k = 2; k <= NR; k++) n[k] = m[k-1];
        if (fl) begin
            for (int k = 1; k <= FS; k++) n[k] = bub();
        end else if (st) begin
            for (int k = 1; k <= SS; k++) n[k] = m[k];
            n[SS+1] = bub();
        end
        m = n;
        for (int i = 0; i < 4; i++) begin
            if (inc[i]) begin
                c32[i] = sat(c32[i], 32);
                c4[i] = sat(c4[i], 4);
            end
        end
    endtask

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic drive(bit st, bit fl, logic [31:0] p);
        i_stall = st;
        i_flush = fl;
        i_pc = p;
        i_instr = mk_ins(p);
    endtask

    task automatic edge1();
        @(posedge clk);
        if (!reset) m_edge(i_stall, i_flush, i_pc, i_instr);
        #2;
    endtask

    task automatic cyc(bit st, bit fl, logic [31:0] p);
        drive(st, fl, p);
        edge1();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("fetch_ack", fetch_ack, !i_stall && !i_flush);
            for (int k = 1; k <= NR; k++) begin
                chk($sformatf("valid%0d", k), valid[k-1], m[k].v);
                chk($sformatf("pc%0d", k), pc[32*k-1 -: 32], m[k].pc);
                chk($sformatf("instr%0d", k), instr[32*k-1 -: 32], m[k].ins);
            end
            chk("retire", retire, m[NR].v);
            chk("retire_pc", retire_pc, m[NR].pc);
            chk("cyc_cnt", cyc_cnt, ec(c32[0]));
            chk("ret_cnt", ret_cnt, ec(c32[1]));
            chk("stall_cnt", stall_cnt, ec(c32[2]));
            chk("flush_cnt", flush_cnt, ec(c32[3]));
            chk("s_valid", s_valid, valid);
            chk("s_cyc", s_cyc, ec(c4[0]));
            chk("s_ret", s_ret, ec(c4[1]));
            chk("s_stall", s_stl, ec(c4[2]));
            chk("s_flush", s_fls, ec(c4[3]));
        end
    end

    initial begin
        #2;
        reset = 1'b1;
        m_reset();
        run = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;

        // fill: retire begins after four edges
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 32'(4 * i));
            if (i == 3) begin
                chk("t1_retire", retire, 1);
                chk("t1_rpc0", retire_pc, 0);
            end
        end
        chk("t1_ret_cnt", ret_cnt, ec(4));
        chk("t1_cyc_cnt", cyc_cnt, ec(8));
        chk("t1_rpc16", retire_pc, 16);

        // single stall with R1.pc=8
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 0, 32'(4 * i));
        drive(1, 0, 12);
        #1;
        chk("t2_ack", fetch_ack, 0);
        edge1();
        chk("t2_r1pc", pc[31:0], 8);
        chk("t2_r2v", valid[1], 0);
        chk("t2_r2ins", instr[63:32], 32'h13);
        chk("t2_r3pc", pc[95:64], 4);
        chk("t2_stall", stall_cnt, ec(1));

        // flush, then flush together with stall
        for (int s = 0; s < 2; s++) begin
            do_reset();
            for (int i = 0; i < 4; i++) cyc(0, 0, 32'(4 * i));
            cyc(s[0], 1, 16);
            chk("t3_r1v", valid[0], 0);
            chk("t3_r2v", valid[1], 0);
            chk("t3_r3v", valid[2], 1);
            chk("t3_r3pc", pc[95:64], 8);
            chk("t3_flush", flush_cnt, ec(1));
            chk("t3_stall", stall_cnt, ec(0));
            cyc(0, 0, 100);
            chk("t3_rpc8", retire_pc, 8);
            cyc(0, 0, 104);
            chk("t3_noret", retire, 0);
        end

        // reset mid-stream clears before the next edge
        for (int i = 0; i < 6; i++) cyc(0, 0, 32'(200 + 4 * i));
        chk("t5_full", valid, 4'hF);
        reset = 1'b1;
        #1;
        m_reset();
        chk("t5_valid", valid, 0);
        chk("t5_cyc", cyc_cnt, 0);
        chk("t5_ret", ret_cnt, 0);
        chk("t5_scyc", s_cyc, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // 4-bit counters saturate
        for (int i = 0; i < 20; i++) cyc(0, 0, 32'(4 * i));
        chk("t6_scyc", s_cyc, ec(15));
        chk("t6_cyc", cyc_cnt, ec(20));

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(3) == 0, $urandom_range(7) == 0,
                    {$urandom_range(32'h3FFF_FFFF), 2'b00});
            end
        end

        drive(0, 0, 0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
